serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 22 ++
 rtl/serial_adder_full_adder.sv | 22 ++
 rtl/serial_adder.sv | 159 +++++++++++++++
 tb/tb_serial_adder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_pkg
//  Description : Shared definitions for the bit-serial adder/subtractor:
//                FSM state encodings and the bit-counter width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package serial_adder_pkg;

    // FSM state encodings
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // The bit counter has to hold the value WIDTH once the last bit has
    // been processed, so it needs clog2(WIDTH+1) bits.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_adder_full_adder.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder
//  Description : Combinational one-bit full adder used as the shared
//                arithmetic cell of the bit-serial adder.
//  Ports       : a, b, ci  - operand bits and carry-in
//                s, co     - sum bit and carry-out
//  Revision    : 1.0  initial release
// ============================================================================
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : WIDTH-bit bit-serial adder/subtractor. Operands are latched
//                on an accepted start and summed LSB-first, one bit per
//                clock, through a single full-adder cell and a carry flop.
//  Ports       : clk, reset (sync, active-high)
//                start, sub, a, b, cin - request and operands
//                busy, done            - handshake status
//                sum, cy               - result and carry (1 = no borrow)
//                ovf                   - signed overflow (SERIAL_ADDER_OVF_EN)
//  Config      : define SERIAL_ADDER_OVF_EN to add the ovf output.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cy
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int                 C_CNT_W    = cnt_width(WIDTH);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(WIDTH - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic [WIDTH-1:0]   w_sum_shift;
    logic [C_CNT_W-1:0] r_cnt;
    logic               r_carry;
    logic               r_cy;
    logic               r_done;
    logic               w_s;
    logic               w_co;
    logic               w_accept;
    logic               w_last;

    // done is a registered strobe taken from the DONE state, so the pulse
    // lands one edge after the FSM leaves RUN. The operation stays "busy"
    // until that strobe has been seen, which keeps a start presented in
    // the done cycle from being accepted.
    assign w_accept = (r_state == IDLE) && !r_done && start;
    assign w_last   = (r_state == RUN) && (r_cnt == C_CNT_LAST);

    full_adder u_fa (
        .a  (r_a[0]),
        .b  (r_b[0]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 is the LSB.
    if (WIDTH == 1) begin : g_sum_w1
        assign w_sum_shift = w_s;
    end else begin : g_sum_wn
        assign w_sum_shift = {w_s, r_sum[WIDTH-1:1]};
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = RUN;
            RUN:     if (w_last)   w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath. Subtraction is a + ~b + 1: the operand inversion and the
    // forced carry-in are applied at load time, so the add/sub choice is
    // fully captured in r_b and r_carry and no mode flag is kept.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cy    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= (r_state == DONE);
            if (w_accept) begin
                r_a     <= a;
                r_b     <= sub ? ~b : b;
                r_carry <= sub ? 1'b1 : cin;
                r_cnt   <= '0;
                r_sum   <= '0;
                r_cy    <= 1'b0;
            end else if (r_state == RUN) begin
                r_a     <= r_a >> 1;
                r_b     <= r_b >> 1;
                r_sum   <= w_sum_shift;
                r_carry <= w_co;
                r_cnt   <= r_cnt + C_CNT_ONE;
                if (w_last) begin
                    r_cy <= w_co;
                end
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // Two's-complement overflow: carry into the MSB differs from carry out.
    // On the final RUN edge r_carry is exactly the carry into the MSB.
    logic r_ovf;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= r_carry ^ w_co;
        end
    end

    assign ovf = r_ovf;
`endif

    assign busy = (r_state != IDLE) || r_done;
    assign done = r_done;
    assign sum  = r_sum;
    assign cy   = r_cy;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Self-checking bench for serial_adder (WIDTH=8). Expected
//                results come from a behavioural model, are queued when an
//                operation is started and compared when done is observed.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_adder;

    localparam int WIDTH = 8;
    localparam int LAT   = WIDTH + 1;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cy;
        logic             ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    wire              busy;
    wire              done;
    wire  [WIDTH-1:0] sum;
    wire              cy;
`ifdef SERIAL_ADDER_OVF_EN
    wire              ovf;
`endif

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cy    (cy)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                                   input logic tcin, input logic tsub);
        exp_t             e;
        logic [WIDTH-1:0] be;
        logic [WIDTH:0]   r;
        be    = tsub ? ~tb : tb;
        r     = {1'b0, ta} + {1'b0, be} + {{WIDTH{1'b0}}, (tsub ? 1'b1 : tcin)};
        e.sum = r[WIDTH-1:0];
        e.cy  = r[WIDTH];
        e.ovf = (ta[WIDTH-1] == be[WIDTH-1]) && (r[WIDTH-1] != ta[WIDTH-1]);
        return e;
    endfunction

    // Presents a start at a negedge; returns #1 after the accepting edge
    // with the operand inputs scrambled to show they were latched.
    task automatic push_start(input string name, input logic [WIDTH-1:0] ta,
                              input logic [WIDTH-1:0] tb, input logic tcin, input logic tsub);
        @(negedge clk);
        a = ta; b = tb; cin = tcin; sub = tsub; start = 1'b1;
        sb.push_back(model(ta, tb, tcin, tsub));
        @(posedge clk); #1;
        start = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL %s busy_after_start: got %b want 1", name, busy);
        end
    endtask

    // poke=1 additionally presents start mid-RUN and in the done cycle and
    // requires both to be ignored.
    task automatic run_op(input string name, input logic [WIDTH-1:0] ta,
                          input logic [WIDTH-1:0] tb, input logic tcin,
                          input logic tsub, input bit poke);
        exp_t e;
        int   lat;
        int   extra;
        bit   seen;
        push_start(name, ta, tb, tcin, tsub);
        lat = 0;
        if (poke) begin
            @(posedge clk); @(posedge clk); #1;
            a = 8'hAA; b = 8'h55; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            lat = 3;
        end
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (done === 1'b1) seen = 1'b1;
        end
        e = sb.pop_front();
        total++;
        if (!seen) begin
            bad++; $display("FAIL %s done_timeout: no done after %0d edges want %0d", name, lat, LAT);
        end else begin
            if (lat !== LAT) begin
                bad++; $display("FAIL %s latency: got %0d want %0d", name, lat, LAT);
            end
            total++;
            if (sum !== e.sum) begin
                bad++; $display("FAIL %s sum: got %h want %h", name, sum, e.sum);
            end
            total++;
            if (cy !== e.cy) begin
                bad++; $display("FAIL %s cy: got %b want %b", name, cy, e.cy);
            end
`ifdef SERIAL_ADDER_OVF_EN
            total++;
            if (ovf !== e.ovf) begin
                bad++; $display("FAIL %s ovf: got %b want %b", name, ovf, e.ovf);
            end
`endif
        end
        if (poke) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL %s idle_after_done: busy=%b done=%b want 0 0", name, busy, done);
        end
        if (poke) begin
            extra = 0;
            repeat (WIDTH + 4) begin
                @(posedge clk); #1;
                if (done === 1'b1 || busy === 1'b1) extra++;
            end
            total++;
            if (extra != 0) begin
                bad++; $display("FAIL %s ignored_start: got %0d busy/done cycles want 0", name, extra);
            end
            total++;
            if (sum !== e.sum) begin
                bad++; $display("FAIL %s sum_held: got %h want %h", name, sum, e.sum);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; sub = 1'b0; cin = 1'b1; a = 8'h12; b = 8'h34;
        repeat (2) begin
            @(posedge clk); #1;
            total++;
            if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cy !== 1'b0) begin
                bad++; $display("FAIL reset_state: busy=%b done=%b sum=%h cy=%b want 0 0 00 0",
                                busy, done, sum, cy);
            end
        end
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL reset_no_start: busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_basic_add();
        run_op("basic_add", 8'h3C, 8'h5A, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_carry_chain();
        run_op("carry_chain", 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_sub_borrow();
        run_op("sub_borrow", 8'h10, 8'h20, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_busy_ignore();
        run_op("busy_ignore", 8'h81, 8'h7E, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_abort();
        exp_t e;
        int   dones;
        push_start("abort", 8'h7F, 8'h01, 1'b0, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL abort busy_mid_run: got %b want 1", busy);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        e = sb.pop_front();
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cy !== 1'b0) begin
            bad++; $display("FAIL abort outputs: busy=%b done=%b sum=%h cy=%b want 0 0 00 0 (dropped %h)",
                            busy, done, sum, cy, e.sum);
        end
`ifdef SERIAL_ADDER_OVF_EN
        total++;
        if (ovf !== 1'b0) begin
            bad++; $display("FAIL abort ovf: got %b want 0", ovf);
        end
`endif
        dones = 0;
        repeat (2 * WIDTH + 4) begin
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
        end
        total++;
        if (dones != 0) begin
            bad++; $display("FAIL abort no_done: got %0d pulses want 0", dones);
        end
    endtask

    task automatic test_signed_ovf();
        run_op("signed_ovf", 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (sum !== 8'h80 || cy !== 1'b0) begin
            bad++; $display("FAIL ovf_hold sum/cy: got %h %b want 80 0", sum, cy);
        end
`ifdef SERIAL_ADDER_OVF_EN
        total++;
        if (ovf !== 1'b1) begin
            bad++; $display("FAIL ovf_hold: got %b want 1", ovf);
        end
        push_start("ovf_clear", 8'h01, 8'h01, 1'b0, 1'b0);
        total++;
        if (ovf !== 1'b0 || sum !== '0) begin
            bad++; $display("FAIL ovf_clear_on_start: ovf=%b sum=%h want 0 00", ovf, sum);
        end
        void'(sb.pop_front());
        repeat (LAT + 2) @(posedge clk);
        #1;
`endif
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            run_op("back_to_back", WIDTH'($urandom), WIDTH'($urandom),
                   1'($urandom), 1'($urandom), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_carry_chain();
        test_sub_borrow();
        test_busy_ignore();
        test_abort();
        test_signed_ovf();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
